// File: rtl/udp_frame_tx_if.sv
// Payload byte stream into udp_frame_tx: valid/ready handshake with end-of-frame marker.
interface udp_frame_tx_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/udp_frame_tx.sv
// Buffers one UDP payload, then emits preamble, Ethernet/IPv4/UDP headers, payload, pad and FCS on GMII.
// Optional macro UDP_TX_CSUM_EN: compute the UDP checksum (otherwise the field is sent as 0x0000).
module udp_frame_tx #(
  parameter logic [47:0] SRC_MAC     = 48'h001122334455,
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [31:0] SRC_IP      = 32'hC0A80064,
  parameter logic [31:0] DST_IP      = 32'hC0A80062,
  parameter logic [15:0] SRC_PORT    = 16'd12345,
  parameter logic [15:0] DST_PORT    = 16'd5555,
  parameter int          MAX_PAYLOAD = 64,
  parameter int          IFG_CYCLES  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  udp_frame_tx_if.slave      s,
  output logic [7:0]         gmii_txd,
  output logic               gmii_tx_en,
  output logic               gmii_tx_er,
  output logic               busy,
  output logic               frame_done,
  output logic               overflow,
  output logic [31:0]        frame_count
);

  localparam int          AW   = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [15:0] MAXP = 16'(MAX_PAYLOAD);
  localparam logic [15:0] IFGC = 16'(IFG_CYCLES);
  // Every IPv4 header word except total length and the checksum itself.
  localparam logic [31:0] IP_CONST = 32'h4500 + 32'h0001 + 32'h4000 + 32'h4011 +
                                     {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]} +
                                     {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};

  typedef enum logic [2:0] {LOAD, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, IFG} state_t;

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [15:0] len_reg;
  logic [31:0] crc_reg;
  logic [15:0] ip_csum_reg;
  logic        s_ready_reg;
  logic [7:0]  gmii_txd_reg;
  logic        gmii_tx_en_reg;
  logic        busy_reg;
  logic        frame_done_reg;
  logic        overflow_reg;
  logic [31:0] frame_count_reg;

  logic [7:0]  mem [MAX_PAYLOAD];
  logic [7:0]  rd_data_reg;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;

  logic        accept;
  logic        store;
  logic [15:0] ip_len;
  logic [15:0] udp_len;
  logic [15:0] udp_csum;
  logic [335:0] hdr_vec;
  logic [7:0]  hdr_bytes [64];
  logic [31:0] fcs_word;
  logic [7:0]  tx_byte;
  logic [31:0] ip_sum;
  logic [16:0] ip_f1;
  logic [15:0] ip_f2;

  assign s.s_ready   = s_ready_reg;
  assign gmii_txd    = gmii_txd_reg;
  assign gmii_tx_en  = gmii_tx_en_reg;
  assign gmii_tx_er  = 1'b0;
  assign busy        = busy_reg;
  assign frame_done  = frame_done_reg;
  assign overflow    = overflow_reg;
  assign frame_count = frame_count_reg;

  assign accept  = s.s_valid & s_ready_reg;
  assign store   = accept & (len_reg < MAXP);
  assign ip_len  = len_reg + 16'd28;
  assign udp_len = len_reg + 16'd8;
  assign wr_addr = AW'(len_reg);

  assign ip_sum = IP_CONST + {16'h0, ip_len};
  assign ip_f1  = {1'b0, ip_sum[15:0]} + {1'b0, ip_sum[31:16]};
  assign ip_f2  = ip_f1[15:0] + {15'h0, ip_f1[16]};

`ifdef UDP_TX_CSUM_EN
  localparam logic [31:0] UDP_CONST = {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]} +
                                      {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]} +
                                      32'h0011 + {16'h0, SRC_PORT} + {16'h0, DST_PORT};
  logic [31:0] udp_acc_reg;
  logic [15:0] udp_csum_reg;
  logic [31:0] udp_sum;
  logic [16:0] udp_f1;
  logic [15:0] udp_f2;
  // udp_len appears twice: once in the pseudo-header, once in the UDP header.
  assign udp_sum  = udp_acc_reg + UDP_CONST + {15'h0, udp_len, 1'b0};
  assign udp_f1   = {1'b0, udp_sum[15:0]} + {1'b0, udp_sum[31:16]};
  assign udp_f2   = udp_f1[15:0] + {15'h0, udp_f1[16]};
  assign udp_csum = udp_csum_reg;
`else
  assign udp_csum = 16'h0000;
`endif

  assign hdr_vec = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, ip_len, 16'h0001, 16'h4000,
                    8'h40, 8'h11, ip_csum_reg, SRC_IP, DST_IP, SRC_PORT, DST_PORT,
                    udp_len, udp_csum};

  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_hdr
      if (gi < 42) begin : g_byte
        assign hdr_bytes[gi] = hdr_vec[8*(41-gi) +: 8];
      end else begin : g_zero
        assign hdr_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  assign fcs_word = ~crc_reg;

  always_comb begin
    tx_byte = 8'h00;
    case (state_reg)
      PREAMBLE: tx_byte = (cnt_reg == 16'd7) ? 8'hD5 : 8'h55;
      HEADER:   tx_byte = hdr_bytes[cnt_reg[5:0]];
      PAYLOAD:  tx_byte = rd_data_reg;
      FCS:      tx_byte = fcs_word[{cnt_reg[1:0], 3'b000} +: 8];
      default:  tx_byte = 8'h00;
    endcase
  end

  // Prefetch one byte ahead so the registered read lines up with the PAYLOAD counter.
  always_comb begin
    rd_addr = '0;
    if (state_reg == PAYLOAD && (cnt_reg + 16'd1) < MAXP)
      rd_addr = AW'(cnt_reg + 16'd1);
  end

  always_ff @(posedge clk) begin
    if (store)
      mem[wr_addr] <= s.s_data;
    rd_data_reg <= mem[rd_addr];
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= LOAD;
      cnt_reg         <= '0;
      len_reg         <= '0;
      crc_reg         <= '0;
      ip_csum_reg     <= '0;
      s_ready_reg     <= 1'b0;
      gmii_txd_reg    <= 8'h00;
      gmii_tx_en_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      overflow_reg    <= 1'b0;
      frame_count_reg <= '0;
`ifdef UDP_TX_CSUM_EN
      udp_acc_reg     <= '0;
      udp_csum_reg    <= '0;
`endif
    end else begin
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      s_ready_reg    <= 1'b0;
      gmii_txd_reg   <= tx_byte;
      gmii_tx_en_reg <= 1'b1;
      case (state_reg)
        LOAD: begin
          gmii_txd_reg   <= 8'h00;
          gmii_tx_en_reg <= 1'b0;
          s_ready_reg    <= 1'b1;
          if (accept) begin
            busy_reg <= 1'b1;
            if (store) begin
              len_reg <= len_reg + 16'd1;
`ifdef UDP_TX_CSUM_EN
              udp_acc_reg <= udp_acc_reg + (len_reg[0] ? {24'h0, s.s_data}
                                                       : {16'h0, s.s_data, 8'h00});
`endif
            end else begin
              overflow_reg <= 1'b1;
            end
            // The first preamble byte goes out on the edge that accepts s_last.
            if (s.s_last) begin
              s_ready_reg    <= 1'b0;
              state_reg      <= PREAMBLE;
              cnt_reg        <= 16'd1;
              gmii_txd_reg   <= 8'h55;
              gmii_tx_en_reg <= 1'b1;
            end
          end
        end
        PREAMBLE: begin
          crc_reg     <= 32'hFFFFFFFF;
          ip_csum_reg <= ~ip_f2;
`ifdef UDP_TX_CSUM_EN
          udp_csum_reg <= (~udp_f2 == 16'h0000) ? 16'hFFFF : ~udp_f2;
`endif
          if (cnt_reg == 16'd7) begin
            state_reg <= HEADER;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        HEADER: begin
          crc_reg <= crc_step(crc_reg, tx_byte);
          if (cnt_reg == 16'd41) begin
            state_reg <= PAYLOAD;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        PAYLOAD: begin
          crc_reg <= crc_step(crc_reg, tx_byte);
          if (cnt_reg == len_reg - 16'd1) begin
            // Pad continues the payload index until 18 bytes follow the 42-byte header.
            if (len_reg < 16'd18) begin
              state_reg <= PAD;
              cnt_reg   <= len_reg;
            end else begin
              state_reg <= FCS;
              cnt_reg   <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        PAD: begin
          crc_reg <= crc_step(crc_reg, tx_byte);
          if (cnt_reg == 16'd17) begin
            state_reg <= FCS;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        FCS: begin
          if (cnt_reg == 16'd3) begin
            state_reg <= IFG;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        default: begin
          gmii_txd_reg   <= 8'h00;
          gmii_tx_en_reg <= 1'b0;
          if (cnt_reg == 16'd0) begin
            frame_done_reg  <= 1'b1;
            frame_count_reg <= frame_count_reg + 32'd1;
          end
          if (cnt_reg == IFGC) begin
            state_reg   <= LOAD;
            cnt_reg     <= '0;
            len_reg     <= '0;
            busy_reg    <= 1'b0;
            s_ready_reg <= 1'b1;
`ifdef UDP_TX_CSUM_EN
            udp_acc_reg <= '0;
`endif
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/udp_frame_tx.md
UDP_FRAME_TX -- requirements
Module: udp_frame_tx

Interface
REQ-001 SHALL have parameter SRC_MAC, default 48'h001122334455, source MAC.
REQ-002 SHALL have parameter DST_MAC, default 48'hFFFFFFFFFFFF, destination MAC.
REQ-003 SHALL have parameter SRC_IP, default 32'hC0A80064, source IPv4.
REQ-004 SHALL have parameter DST_IP, default 32'hC0A80062, destination IPv4.
REQ-005 SHALL have parameter SRC_PORT, default 16'd12345, and DST_PORT, default 16'd5555, UDP ports.
REQ-006 SHALL have parameter MAX_PAYLOAD, default 64, payload buffer depth in bytes (range 1..1472).
REQ-007 SHALL have parameter IFG_CYCLES, default 12, minimum idle cycles between frames.
REQ-008 SHALL have ports (one clock; reset asynchronous, active-low):
- clk  in  1  GMII clock, 125 MHz
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  payload byte valid
- s_ready  out  1  payload byte accepted when s_valid & s_ready
- s_data  in  8  payload byte
- s_last  in  1  final payload byte of frame
- gmii_txd  out  8  GMII data
- gmii_tx_en  out  1  GMII enable
- gmii_tx_er  out  1  GMII error, constant 0
- busy  out  1  high from first accepted byte until IFG end
- frame_done  out  1  one-cycle pulse after last FCS byte
- overflow  out  1  one-cycle pulse when a byte is discarded past MAX_PAYLOAD
- frame_count  out  32  frames transmitted, wraps at 2^32

Function
REQ-009 SHALL use states LOAD, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, IFG; LOAD is the idle state.
REQ-010 s_ready SHALL be 1 only in LOAD; payload bytes SHALL be stored in order into the buffer.
REQ-011 Bytes accepted beyond MAX_PAYLOAD SHALL be discarded, each pulsing overflow; the frame carries MAX_PAYLOAD bytes.
REQ-012 Accepting s_last SHALL latch length N and enter PREAMBLE; the first preamble byte SHALL appear on gmii_txd with gmii_tx_en=1 on the next cycle.
REQ-013 PREAMBLE: 7x 0x55 then 0xD5.
REQ-014 HEADER: 42 bytes, MSB first: DST_MAC, SRC_MAC, 0x0800, IPv4 (0x45,0x00, total length 28+N, ID 0x0001, 0x4000, TTL 0x40, proto 0x11, header checksum, SRC_IP, DST_IP), UDP (SRC_PORT, DST_PORT, length 8+N, checksum).
REQ-015 IP header checksum SHALL be the ones-complement of the end-around-carry 16-bit sum of the header words, registered before its bytes are sent.
REQ-016 PAYLOAD: N buffered bytes; PAD: 0x00 bytes until 60 frame bytes (DST_MAC..pad) are sent, none if 42+N >= 60; pad excluded from IP/UDP lengths.
REQ-017 FCS: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final inversion) over DST_MAC..pad, least-significant byte first.
REQ-018 After FCS, gmii_tx_en SHALL drop and IFG SHALL hold gmii_tx_en=0 for IFG_CYCLES cycles before LOAD.
REQ-019 gmii_tx_en SHALL be high for exactly 8 + max(60, 42+N) + 4 consecutive cycles per frame.
REQ-020 frame_done SHALL pulse and frame_count SHALL increment in the cycle gmii_tx_en falls.
REQ-021 s_valid without s_last held indefinitely SHALL stall in LOAD with no transmission.

Reset
REQ-022 rst_n low SHALL immediately force: state LOAD, buffer length 0, gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, s_ready=0, busy=0, frame_done=0, overflow=0, frame_count=0.
REQ-023 Reset mid-frame SHALL truncate the frame, with no frame_done pulse and no count increment; s_ready SHALL rise the first cycle after release.

Configuration
REQ-024 With UDP_TX_CSUM_EN defined, UDP checksum SHALL be computed over pseudo-header, UDP header and payload (odd final byte zero-padded), accumulated during LOAD; a result of 0x0000 SHALL be sent as 0xFFFF.
REQ-025 Without UDP_TX_CSUM_EN, UDP checksum field SHALL be 0x0000 and no accumulator SHALL be built.

Verification
REQ-026 20-byte "Hello from Artix A7!" -> IP length 0x0030, UDP length 0x001C, gmii_tx_en high 74 cycles, Wireshark-valid FCS.
REQ-027 N=1 (0xA5) -> 17 pad bytes 0x00, IP length 0x001D, gmii_tx_en high 72 cycles, valid CRC.
REQ-028 70 bytes at MAX_PAYLOAD=64 -> 6 overflow pulses, UDP length 0x0048, gmii_tx_en high 118 cycles.
REQ-029 Two frames, s_valid held high -> gmii_tx_en low >= 12 cycles between them, frame_count=2.
REQ-030 rst_n low during PAYLOAD -> gmii_tx_en 0 same cycle, frame_count unchanged, next frame correct.
REQ-031 UDP checksum vs software model with UDP_TX_CSUM_EN defined; field 0x0000 without it.
